// File: rtl/prog_loader.sv
// Byte-stream program loader: frames a 16-bit instruction image from the UART byte
// stream into instruction memory and holds the core in reset until the checksum verifies.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes discarded
// CNT_HI  | expecting word count high byte
// CNT_LO  | expecting word count low byte, range check
// DATA_HI | expecting instruction high byte
// DATA_LO | expecting instruction low byte, write issued next cycle
// CHECK   | expecting XOR checksum byte
// DONE    | image verified, core released
// ERR     | frame failed (checksum, size or timeout), core held
module prog_loader #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              proc_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;

  state_t            state, nxt;
  logic [15:0]       count;
  logic [7:0]        hold;
  logic [7:0]        checksum;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     tmo_cnt;
  logic              we_q;

  logic              accept;
  logic              tmo_hit;
  logic              too_big;
  logic              last_word;
  logic [15:0]       cnt_full;

  function automatic logic in_frame(input state_t s);
    return s inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
  endfunction

  assign accept    = rx_valid & rx_ready;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign cnt_full  = {count[15:8], rx_data};
  assign too_big   = {17'd0, cnt_full} > MAX_WORDS;
  assign last_word = (words_loaded + 16'd1) == count;

  // The write strobe is registered, but a start landing on the issue cycle still kills it.
  assign imem_we = we_q & ~start;

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    if (rx_data == SYNC_BYTE) nxt = CNT_HI;
        CNT_HI:  nxt = CNT_LO;
        CNT_LO: begin
          if (cnt_full == 16'd0) nxt = CHECK;
          else if (too_big)      nxt = ERR;
          else                   nxt = DATA_HI;
        end
        DATA_HI: nxt = DATA_LO;
        DATA_LO: nxt = last_word ? CHECK : DATA_HI;
        CHECK:   nxt = (rx_data == checksum) ? DONE : ERR;
        default: nxt = state;
      endcase
    end else if (in_frame(state) && tmo_hit) begin
      nxt = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      we_q         <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 16'd0;
      proc_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 16'd0;
      checksum     <= 8'd0;
      tmo_cnt      <= '0;
      count        <= 16'd0;
      hold         <= 8'd0;
      idx          <= '0;
    end else begin
      state    <= nxt;
      rx_ready <= !(nxt == DONE || nxt == ERR);
      busy     <= in_frame(nxt);
      done     <= (nxt == DONE);
      err      <= (nxt == ERR);
      proc_rst <= (nxt != DONE);
      we_q     <= 1'b0;

      // Gap timer only runs while the frame stays open and the line is silent.
      if (in_frame(state) && in_frame(nxt) && !accept)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      if (accept && !start) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              checksum     <= 8'd0;
              words_loaded <= 16'd0;
              idx          <= '0;
            end
          end
          CNT_HI:  count[15:8] <= rx_data;
          CNT_LO:  count[7:0]  <= rx_data;
          DATA_HI: begin
            hold     <= rx_data;
            checksum <= checksum ^ rx_data;
          end
          DATA_LO: begin
            checksum     <= checksum ^ rx_data;
            we_q         <= 1'b1;
            imem_addr    <= idx;
            imem_wdata   <= {hold, rx_data};
            idx          <= idx + ADDR_W'(1);
            words_loaded <= words_loaded + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames from the load scenarios plus randomized framed
// traffic, all compared every cycle against a frame-position reference model.
module tb_prog_loader;

  localparam int AW  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          proc_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   words_loaded;

  prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .proc_rst(proc_rst), .busy(busy), .done(done),
    .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 hunting, 1 in frame, 2 verified, 3 failed; pos = bytes seen after sync.
  int m_mode, m_pos, m_chi, m_count, m_cs, m_hold, m_words, m_tmo, m_addr, m_wdata;
  bit m_rdy, m_pend;

  logic [19:0] wr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_chi = 0; m_count = 0; m_cs = 0; m_hold = 0;
    m_words = 0; m_tmo = 0; m_addr = 0; m_wdata = 0; m_rdy = 0; m_pend = 0;
  endtask

  task automatic model_advance();
    automatic bit acc = rx_valid && m_rdy;
    automatic int b = rx_data;
    m_pend = 0;
    if (start) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (acc && b == 8'hA5) begin
        m_mode = 1; m_pos = 0; m_cs = 0; m_words = 0; m_tmo = 0;
      end
    end else if (m_mode == 1) begin
      if (acc) begin
        m_tmo = 0;
        if (m_pos == 0) begin
          m_chi = b;
        end else if (m_pos == 1) begin
          m_count = m_chi * 256 + b;
          if (m_count > (1 << AW)) m_mode = 3;
        end else if (m_pos < 2 + 2 * m_count) begin
          m_cs = m_cs ^ b;
          if ((m_pos - 2) % 2 == 0) begin
            m_hold = b;
          end else begin
            m_pend  = 1;
            m_addr  = m_words % (1 << AW);
            m_wdata = m_hold * 256 + b;
            m_words = m_words + 1;
          end
        end else begin
          m_mode = (b == m_cs) ? 2 : 3;
        end
        m_pos = m_pos + 1;
      end else begin
        m_tmo = m_tmo + 1;
        if (m_tmo >= TMO) m_mode = 3;
      end
    end
    m_rdy = (m_mode < 2);
  endtask

  task automatic check_outputs();
    chk("rx_ready", rx_ready, m_rdy);
    chk("busy", busy, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("err", err, m_mode == 3);
    chk("proc_rst", proc_rst, m_mode != 2);
    chk("imem_we", imem_we, m_pend && !start);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_wdata", imem_wdata, m_wdata);
    chk("words_loaded", words_loaded, m_words);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    rx_valid = v; rx_data = d; start = s;
    #1;
    check_outputs();
    if (imem_we === 1'b1) wr_log.push_back({imem_addr, imem_wdata});
    model_advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_start();
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_seq(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) step(1'b1, bytes[8*(n-1-i) +: 8], 1'b0);
  endtask

  task automatic chk_wr(input int i, input logic [3:0] a, input logic [15:0] d);
    if (i < wr_log.size()) chk("wr_entry", wr_log[i], {a, d});
    else chk("wr_missing", wr_log.size(), i + 1);
  endtask

  task automatic async_reset_check();
    rst = 1'b0;
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_proc_rst", proc_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    #1;
    rst = 1'b1;
    rx_valid = 1'b0; start = 1'b0;
    model_reset();
    model_advance();
  endtask

  initial begin
    logic [7:0] fb[64];
    int n, cnt, cs, ngar, gap_at, cyc, i;
    bit long_gap, v, acc;
    logic [7:0] b;

    model_reset();
    #12;
    async_reset_check();
    idle(2);

    // Good two-word frame.
    wr_log.delete();
    send_seq(64'hA500021234ABCD40, 8);
    idle(2);
    chk("t1_done", done, 1);
    chk("t1_proc_rst", proc_rst, 0);
    chk("t1_words", words_loaded, 2);
    chk("t1_nwr", wr_log.size(), 2);
    chk_wr(0, 4'h0, 16'h1234);
    chk_wr(1, 4'h1, 16'hABCD);
    pulse_start(); idle(1);

    // Bad checksum.
    wr_log.delete();
    send_seq(64'hA500021234ABCD41, 8);
    idle(2);
    chk("t2_err", err, 1);
    chk("t2_done", done, 0);
    chk("t2_proc_rst", proc_rst, 1);
    chk("t2_nwr", wr_log.size(), 2);
    pulse_start(); idle(1);

    // Empty image behind leading garbage.
    wr_log.delete();
    send_seq(64'h0000_00FFA5000000, 6);
    idle(2);
    chk("t3_done", done, 1);
    chk("t3_proc_rst", proc_rst, 0);
    chk("t3_nwr", wr_log.size(), 0);
    pulse_start(); idle(1);

    // Timeout after first word.
    wr_log.delete();
    send_seq(64'h000000A500031122, 5);
    idle(TMO);
    chk("t4_err_early", err, 0);
    idle(1);
    chk("t4_err", err, 1);
    chk("t4_nwr", wr_log.size(), 1);
    chk_wr(0, 4'h0, 16'h1122);
    pulse_start(); idle(1);

    // Mid-frame abort, then a clean reload from address 0.
    wr_log.delete();
    send_seq(64'h00000000A5000212, 4);
    pulse_start(); idle(1);
    chk("t5_busy", busy, 0);
    send_seq(64'hA500021234ABCD40, 8);
    idle(2);
    chk("t5_done", done, 1);
    chk("t5_nwr", wr_log.size(), 2);
    chk_wr(0, 4'h0, 16'h1234);
    pulse_start(); idle(1);

    // Start on the write-issue cycle suppresses the strobe.
    wr_log.delete();
    send_seq(64'h000000A500011234, 5);
    pulse_start(); idle(1);
    chk("t5b_nwr", wr_log.size(), 0);
    chk("t5b_busy", busy, 0);

    // Oversized count rejected right after the low count byte.
    send_seq(64'h0000000000A50011, 3);
    idle(1);
    chk("t6_err", err, 1);
    chk("t6_rx_ready", rx_ready, 0);
    pulse_start(); idle(1);

    // Largest image that fits: 16 words.
    wr_log.delete();
    send_seq(64'h0000000000A50010, 3);
    cs = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 8'(k), 1'b0);
      step(1'b1, 8'(8'h50 + k), 1'b0);
      cs = cs ^ k ^ (8'h50 + k);
    end
    step(1'b1, 8'(cs), 1'b0);
    idle(2);
    chk("t7_done", done, 1);
    chk("t7_words", words_loaded, 16);
    chk("t7_nwr", wr_log.size(), 16);
    chk_wr(0, 4'h0, 16'h0050);
    chk_wr(15, 4'hF, 16'h0F5F);
    pulse_start(); idle(1);

    // Asynchronous reset mid-frame.
    send_seq(64'h00000000A5000212, 4);
    async_reset_check();
    idle(2);

    // Randomized framed traffic.
    for (int f = 0; f < 150; f++) begin
      n = 0; cs = 0;
      ngar = $urandom_range(0, 2);
      for (int g = 0; g < ngar; g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        fb[n] = b; n++;
      end
      fb[n] = 8'hA5; n++;
      cnt = $urandom_range(0, 18);
      fb[n] = 8'(cnt >> 8); n++;
      fb[n] = 8'(cnt); n++;
      for (int k = 0; k < 2 * cnt; k++) begin
        b = 8'($urandom);
        cs = cs ^ b;
        fb[n] = b; n++;
      end
      fb[n] = ($urandom_range(0, 4) == 0) ? 8'(cs ^ 1) : 8'(cs); n++;
      long_gap = ($urandom_range(0, 11) == 0);
      gap_at = $urandom_range(ngar + 1, n - 1);
      i = 0; cyc = 0;
      while (i < n && m_mode < 2 && cyc < 400) begin
        if (long_gap && i == gap_at) begin
          idle(TMO + 2);
          long_gap = 0;
        end else if ($urandom_range(0, 299) == 0) begin
          pulse_start();
          i = n;
        end else begin
          v = ($urandom_range(0, 3) != 0);
          acc = v && m_rdy;
          step(v, v ? fb[i] : 8'($urandom), 1'b0);
          if (acc) i++;
        end
        cyc++;
      end
      idle(2);
      pulse_start();
      idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that writes a 16-bit instruction image into the processor's instruction memory write port.
- Holds the processor core in reset while loading; releases it only after a framed image passes checksum.
- Sits between the UART receive byte interface and the fetch-stage instruction memory. It is the writer end of the instruction memory that fetch reads.

Parameters:
- ADDR_W, 16, instruction memory word-address width; images longer than 2^ADDR_W words are rejected.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000000, max clk cycles allowed between accepted bytes inside a frame.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  level/pulse request to abort and re-arm a load (synchronous, sampled each cycle)
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte this cycle
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address of write
- imem_wdata  output  16  instruction word
- proc_rst  output  1  active-high reset to processor core
- busy  output  1  frame in progress (states CNT_HI..CHECK)
- done  output  1  last frame loaded and verified
- err  output  1  last frame failed
- words_loaded  output  16  words written in current/last frame

Behaviour:
- Reset (rst=0, async): state=IDLE; proc_rst=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, words_loaded=0, checksum=0, timeout counter=0.
- Byte accepted iff rx_valid & rx_ready on a rising edge.
- rx_ready=1 in IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK; 0 in DONE, ERR.
- rx_ready must never depend combinationally on rx_valid.

State machine:
- IDLE:
  - byte==SYNC_BYTE -> CNT_HI; clear checksum, words_loaded, word index.
  - Any other byte is discarded; stay in IDLE.
- CNT_HI: byte -> count[15:8]; -> CNT_LO.
- CNT_LO: byte -> count[7:0]; then:
  - count==0 -> CHECK.
  - count > 2^ADDR_W -> ERR.
  - otherwise -> DATA_HI.
- DATA_HI: byte -> hold register; checksum ^= byte; -> DATA_LO.
- DATA_LO:
  - checksum ^= byte.
  - Next cycle: imem_we=1 for exactly one cycle, imem_wdata={hold,byte} (big-endian), imem_addr=word index.
  - word index and words_loaded increment by 1.
  - If that was word count-1 -> CHECK, else -> DATA_HI.
- CHECK: byte compared to checksum (XOR of all data bytes; 8'h00 when count==0). Equal -> DONE, else -> ERR.
- DONE: done=1, err=0, proc_rst=0; stay until start.
- ERR: err=1, done=0, proc_rst=1; stay until start.

Control rules:
- proc_rst=1 in every state except DONE.
- start=1 in any state -> IDLE next cycle, proc_rst=1, done=0, err=0; the in-flight frame is abandoned.
- start has priority over a simultaneous byte accept; that byte is dropped.
- imem_we is suppressed if start is asserted in the same cycle the write would issue.
- Timeout:
  - Counter clears on every accepted byte and on entry to CNT_HI.
  - Increments in CNT_HI..CHECK.
  - Reaching TIMEOUT -> ERR. No timeout in IDLE, DONE, ERR.
- Address never wraps: the count limit guarantees imem_addr <= 2^ADDR_W-1.
- An async reset mid-frame returns all state to reset values immediately; memory contents are left as written.
- Write latency: imem_we asserts on the cycle after the low byte is accepted. Back-to-back bytes therefore sustain 1 word per 2 bytes with no stalls.

Test Plan:
- Reset then frame A5 00 02 12 34 AB CD 40 -> imem writes (addr0, 16'h1234) and (addr1, 16'hABCD), one-cycle imem_we each; done=1, proc_rst=0, words_loaded=2.
- Same frame with checksum byte 41 -> both words written, err=1, done=0, proc_rst stays 1.
- Frame A5 00 00 00 -> no imem_we; done=1, proc_rst=0. Leading garbage bytes 00 FF before A5 are ignored.
- Frame A5 00 03 11 22, then rx_valid held low for TIMEOUT cycles (TIMEOUT=16 in bench) -> err=1 at cycle 16 after last byte; one word (addr0, 16'h1122) written.
- Mid-frame start pulse after A5 00 02 12 -> IDLE, no write. A following full valid frame loads correctly from addr0.
- With ADDR_W=4, count 00 11 (17) -> ERR immediately after CNT_LO. Count 00 10 (16) loads addr 0..15 and reaches DONE. Also: rst low mid-frame -> all outputs at reset values asynchronously.
